// File: rtl/ysyx_25070198_sram.sv
// Word-addressed SRAM behind a single-outstanding LSU request port.
// Response latency is either fixed or drawn from a free-running LFSR, to stress the requester.
module ysyx_25070198_sram #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter bit          RAND_LAT  = 1'b1,
    parameter int          FIXED_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    input  logic        lsu_reqValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_respValid,
    output logic        lsu_respErr,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic [7:0]    lfsr;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;
    logic          wen_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          finish;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [3:0]    delay;
    logic          lfsr_fb;

    assign accept   = (state == IDLE) && lsu_reqValid;
    assign finish   = (state == WAIT) && (cnt == 4'd0);
    // Unsigned wrap makes addresses below BASE land far outside the window.
    assign offset   = addr_q - BASE;
    assign in_range = (offset >> (AW + 2)) == 32'd0;
    assign idx      = offset[AW+1:2];
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign delay    = RAND_LAT ? {2'b00, lfsr[1:0]} : 4'(FIXED_LAT);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lsu_reqValid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            lfsr          <= 8'hA5;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            wmask_q       <= 4'd0;
            wen_q         <= 1'b0;
            lsu_rdata     <= 32'd0;
            lsu_respValid <= 1'b0;
            lsu_respErr   <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= {lfsr[6:0], lfsr_fb};
            if (accept) begin
                addr_q  <= lsu_addr;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
                wen_q   <= lsu_wen;
                cnt     <= delay;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            lsu_respValid <= finish;
            lsu_respErr   <= finish && !in_range;
            lsu_rdata     <= (finish && in_range && !wen_q) ? mem[idx] : 32'd0;
        end
    end

    // Write commits on the WAIT->RESP edge, so a reset during WAIT drops it.
    always_ff @(posedge clk) begin
        if (rst && finish && in_range && wen_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25070198_sram.sv
// Directed checks of the SRAM port with fixed latency 0 and 3, plus a randomized
// back-to-back run against a reference memory with LFSR latency.
module tb_ysyx_25070198_sram;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        req [3];
    logic [31:0] rd [3];
    logic        rv [3];
    logic        err [3];
    logic        bsy [3];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    ysyx_25070198_sram #(.RAND_LAT(1'b0), .FIXED_LAT(0)) u_fix0 (
        .clk(clk), .rst(rst), .lsu_addr(addr), .lsu_wen(wen), .lsu_wdata(wdata),
        .lsu_wmask(wmask), .lsu_reqValid(req[0]), .lsu_rdata(rd[0]),
        .lsu_respValid(rv[0]), .lsu_respErr(err[0]), .busy(bsy[0]));

    ysyx_25070198_sram #(.RAND_LAT(1'b0), .FIXED_LAT(3)) u_fix3 (
        .clk(clk), .rst(rst), .lsu_addr(addr), .lsu_wen(wen), .lsu_wdata(wdata),
        .lsu_wmask(wmask), .lsu_reqValid(req[1]), .lsu_rdata(rd[1]),
        .lsu_respValid(rv[1]), .lsu_respErr(err[1]), .busy(bsy[1]));

    ysyx_25070198_sram #(.RAND_LAT(1'b1)) u_rand (
        .clk(clk), .rst(rst), .lsu_addr(addr), .lsu_wen(wen), .lsu_wdata(wdata),
        .lsu_wmask(wmask), .lsu_reqValid(req[2]), .lsu_rdata(rd[2]),
        .lsu_respValid(rv[2]), .lsu_respErr(err[2]), .busy(bsy[2]));

    // Issues one request on instance sel; lat = edges from acceptance to the
    // respValid sample, -1 if no response within the budget.
    task automatic xact(input int sel, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] r, output logic e, output int lat);
        @(posedge clk); #1;
        addr = a; wen = w; wdata = d; wmask = m; req[sel] = 1'b1;
        @(posedge clk); #1;
        addr = ~a; wen = 1'b0; wdata = 32'h0; wmask = 4'h0;
        lat = -1; r = 32'hx; e = 1'bx;
        for (int i = 0; i < 20; i++) begin
            if (rv[sel]) begin
                lat = i; r = rd[sel]; e = err[sel];
                break;
            end
            @(posedge clk); #1;
        end
        req[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = 1'b1;
        addr = 32'h8000_0000; wen = 1'b1; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bsy[i] !== 1'b0 || rv[i] !== 1'b0 || err[i] !== 1'b0 || rd[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: busy=%b resp=%b err=%b rdata=%h, want 0/0/0/0",
                         i, bsy[i], rv[i], err[i], rd[i]);
            end
        end
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        wen = 1'b0; wmask = 4'h0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy=%b want 0", bsy[0]);
        end
    endtask

    task automatic test_fixed0();
        logic [31:0] r; logic e; int lat;
        xact(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL f0_write: lat=%0d err=%b rdata=%h want 1/0/00000000", lat, e, r);
        end
        xact(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL f0_read: lat=%0d err=%b rdata=%h want 1/0/deadbeef", lat, e, r);
        end
        xact(0, 32'h8000_0010, 1'b1, 32'h0000_AB00, 4'b0010, r, e, lat);
        xact(0, 32'h8000_0013, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (r !== 32'hDEAD_ABEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL f0_mask_byte1: rdata=%h err=%b want deadabef/0", r, e);
        end
        xact(0, 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL f0_mask0_resp: lat=%0d err=%b want 1/0", lat, e);
        end
        xact(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (r !== 32'hDEAD_ABEF) begin
            n_fail++;
            $display("FAIL f0_mask0_data: rdata=%h want deadabef", r);
        end
        xact(0, 32'h8000_0FFC, 1'b1, 32'hCAFE_F00D, 4'hF, r, e, lat);
        xact(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (r !== 32'hCAFE_F00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL f0_last_word: rdata=%h err=%b want cafef00d/0", r, e);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] r; logic e; int lat;
        xact(0, 32'h0000_0000, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_low: lat=%0d err=%b rdata=%h want 1/1/00000000", lat, e, r);
        end
        xact(0, 32'h8000_1000, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_high: lat=%0d err=%b rdata=%h want 1/1/00000000", lat, e, r);
        end
        xact(0, 32'h8000_1010, 1'b1, 32'h1111_1111, 4'hF, r, e, lat);
        n_cmp++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_write: lat=%0d err=%b rdata=%h want 1/1/00000000", lat, e, r);
        end
        xact(0, 32'h7FFF_FFFC, 1'b1, 32'h2222_2222, 4'hF, r, e, lat);
        xact(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (r !== 32'hDEAD_ABEF) begin
            n_fail++;
            $display("FAIL oor_no_alias_lo: rdata=%h want deadabef", r);
        end
        xact(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (r !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL oor_no_alias_hi: rdata=%h want cafef00d", r);
        end
    endtask

    task automatic test_fixed3();
        logic [31:0] r; logic e; int lat;
        xact(1, 32'h8000_0040, 1'b1, 32'hA5A5_5A5A, 4'hF, r, e, lat);
        n_cmp++;
        if (lat !== 4 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL f3_write_lat: lat=%0d err=%b want 4/0", lat, e);
        end
        @(posedge clk); #1;
        addr = 32'h8000_0040; wen = 1'b0; req[1] = 1'b1;
        @(posedge clk); #1;
        addr = 32'h8000_0000;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bsy[1] !== 1'b1 || rv[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL f3_wait_cyc%0d: busy=%b resp=%b want 1/0", k, bsy[1], rv[1]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bsy[1] !== 1'b1 || rv[1] !== 1'b1 || rd[1] !== 32'hA5A5_5A5A || err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL f3_resp: busy=%b resp=%b rdata=%h err=%b want 1/1/a5a55a5a/0",
                     bsy[1], rv[1], rd[1], err[1]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bsy[1] !== 1'b0 || rv[1] !== 1'b0 || rd[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL f3_after_resp: busy=%b resp=%b rdata=%h want 0/0/00000000", bsy[1], rv[1], rd[1]);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bsy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL f3_no_reaccept: busy=%b want 0", bsy[1]);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] r; logic e; int lat; int pulses;
        xact(1, 32'h8000_0020, 1'b1, 32'h0, 4'hF, r, e, lat);
        @(posedge clk); #1;
        addr = 32'h8000_0020; wen = 1'b1; wdata = 32'h1234_5678; wmask = 4'hF; req[1] = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0; wdata = 32'h0; wmask = 4'h0; req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bsy[1] !== 1'b0 || rv[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_state: busy=%b resp=%b want 0/0", bsy[1], rv[1]);
        end
        rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv[1] === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rst_wait_no_resp: pulses=%0d want 0", pulses);
        end
        xact(1, 32'h8000_0020, 1'b0, 32'h0, 4'h0, r, e, lat);
        n_cmp++;
        if (lat !== 4 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wait_no_commit: lat=%0d rdata=%h want 4/00000000", lat, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic e; int lat;
        logic [31:0] a, d, exp_r;
        logic [3:0]  m;
        logic        w, exp_e;
        int          idx, kind;
        logic [4:0]  seen;
        seen = 5'b0;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            ref_mem[i] = d;
            xact(2, 32'h8000_0000 + 32'(i) * 4, 1'b1, d, 4'hF, r, e, lat);
            n_cmp++;
            if (lat < 1 || lat > 4 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_fill%0d: lat=%0d err=%b want 1..4/0", i, lat, e);
            end
            if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;
        end
        for (int n = 0; n < 1000; n++) begin
            kind = $urandom_range(0, 9);
            w    = 1'($urandom);
            d    = $urandom;
            m    = 4'($urandom);
            idx  = $urandom_range(0, 63);
            if (kind == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 32'h8000_1000 + 32'(idx) * 4
                                                 : 32'h7FFF_FF00 + 32'(idx) * 4;
                exp_e = 1'b1; exp_r = 32'h0;
            end else begin
                a = 32'h8000_0000 + 32'(idx) * 4 + 32'($urandom_range(0, 3));
                exp_e = 1'b0;
                exp_r = w ? 32'h0 : ref_mem[idx];
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            xact(2, a, w, d, m, r, e, lat);
            n_cmp++;
            if (lat < 1 || lat > 4 || r !== exp_r || e !== exp_e) begin
                n_fail++;
                $display("FAIL b2b_req%0d addr=%h wen=%b: lat=%0d rdata=%h err=%b want 1..4/%h/%b",
                         n, a, w, lat, r, e, exp_r, exp_e);
            end
            if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;
        end
        n_cmp++;
        if (seen[4:1] !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_latencies_seen: mask=%b want 1111", seen[4:1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        addr = 32'h0; wen = 1'b0; wdata = 32'h0; wmask = 4'h0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        test_reset();
        test_fixed0();
        test_out_of_range();
        test_fixed3();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25070198_sram.md
YSYX_25070198_SRAM -- requirements
Module: ysyx_25070198_sram

Interface
REQ-001 SHALL expose parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL expose parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL expose parameter RAND_LAT, default 1: 1 = LFSR-random latency, 0 = fixed latency.
REQ-004 SHALL expose parameter FIXED_LAT, default 0, extra wait cycles (0..15) used when RAND_LAT=0.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-low (asserted when 0).
REQ-007 SHALL have port lsu_addr  input  32  request byte address.
REQ-008 SHALL have port lsu_wen  input  1  1 = write request, 0 = read request.
REQ-009 SHALL have port lsu_wdata  input  32  write data.
REQ-010 SHALL have port lsu_wmask  input  4  byte enables; bit i writes wdata[8i+7:8i].
REQ-011 SHALL have port lsu_reqValid  input  1  request valid.
REQ-012 SHALL have port lsu_rdata  output  32  read data; valid only while lsu_respValid=1.
REQ-013 SHALL have port lsu_respValid  output  1  one-cycle response pulse.
REQ-014 SHALL have port lsu_respErr  output  1  address out of range; valid with lsu_respValid.
REQ-015 SHALL have port busy  output  1  1 while a request is outstanding (states WAIT, RESP).

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP.
REQ-017 In IDLE with lsu_reqValid=1, SHALL accept the request: latch addr, wen, wdata, wmask; load delay counter; go to WAIT.
REQ-018 Latched values only: inputs after acceptance SHALL be ignored (requester drops wen/wdata/wmask and holds reqValid while waiting).
REQ-019 Delay SHALL be FIXED_LAT if RAND_LAT=0, else lfsr[1:0] (0..3) sampled at acceptance.
REQ-020 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle, reset seed 8'hA5; never all-zero.
REQ-021 In WAIT: counter=0 -> go to RESP next edge; else decrement.
REQ-022 Accept at edge T -> lsu_respValid=1 during cycle T+1+delay, for exactly one cycle.
REQ-023 lsu_rdata, lsu_respValid, lsu_respErr SHALL be registered outputs, driven in RESP only; otherwise 0.
REQ-024 In-range: BASE <= addr < BASE+4*DEPTH; word index = (addr-BASE)[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-025 Read in range: lsu_rdata = full stored word (no byte extraction), lsu_respErr=0.
REQ-026 Write in range: masked bytes SHALL commit on the WAIT->RESP edge; unmasked bytes unchanged; lsu_rdata=0 in response.
REQ-027 Out of range: write dropped, lsu_rdata=0, lsu_respErr=1, same latency as in-range.
REQ-028 wmask=4'b0000 write: no bytes change, normal response.
REQ-029 RESP -> IDLE unconditionally; lsu_reqValid in RESP cycle SHALL be ignored (no acceptance).
REQ-030 Earliest next acceptance: cycle after RESP; back-to-back gap therefore >= 1 idle cycle.
REQ-031 lsu_reqValid=0 in WAIT (protocol violation) SHALL NOT abort; request completes normally.
REQ-032 Memory array SHALL NOT be reset; contents undefined until written.

Reset
REQ-033 rst=0 at an edge SHALL force IDLE, counter=0, lsu_respValid=0, lsu_respErr=0, lsu_rdata=0, busy=0, LFSR=8'hA5.
REQ-034 Reset in WAIT SHALL discard the pending request; a pending write SHALL NOT commit.
REQ-035 Reset in RESP SHALL suppress nothing already committed; response pulse ends at that edge.
REQ-036 lsu_reqValid while rst=0 SHALL NOT be accepted.

Verification
REQ-037 FIXED_LAT=0: write 0x8000_0010 data 0xDEADBEEF mask 4'hF accepted at T -> respValid at T+1; read same addr -> rdata 0xDEADBEEF, respErr=0.
REQ-038 Then write 0x8000_0010 data 0x0000AB00 mask 4'b0010 -> read returns 0xDEADABEF.
REQ-039 Read 0x0000_0000 and 0x8000_1000 (DEPTH=1024) -> respValid with respErr=1, rdata=0; no memory change.
REQ-040 FIXED_LAT=3, reqValid held high throughout -> respValid only at T+4, single pulse, no re-acceptance in RESP; busy high T+1..T+4.
REQ-041 Reset asserted in WAIT of write 0x8000_0020=0x12345678 (after prior 0x0) -> no respValid; later read returns 0x0.
REQ-042 RAND_LAT=1, 1000 random back-to-back requests vs reference model -> every latency in 1..4 cycles, data matches, all four latencies observed.
